// File: rtl/pc_reg_stack_pkg.sv
// rtl/pc_reg_stack_pkg.sv - shared PC defaults and action priority encoding
package pc_reg_stack_pkg;

  localparam int                     DEF_PC_W      = 12;
  localparam logic [DEF_PC_W-1:0]    DEF_RESET_VEC = 12'h000;

  localparam logic [2:0] ACT_NONE     = 3'd0;
  localparam logic [2:0] ACT_EN       = 3'd1;
  localparam logic [2:0] ACT_CALL     = 3'd2;
  localparam logic [2:0] ACT_RET      = 3'd3;
  localparam logic [2:0] ACT_CONFLICT = 3'd4;

  // Highest-priority strobe wins; call+ret together is its own action.
  function automatic logic [2:0] sel_action(input logic en, input logic call, input logic ret);
    if (call && ret) return ACT_CONFLICT;
    if (ret)         return ACT_RET;
    if (call)        return ACT_CALL;
    if (en)          return ACT_EN;
    return ACT_NONE;
  endfunction

endpackage

// File: rtl/pc_reg_stack_ras_lifo.sv
// rtl/pc_reg_stack_ras_lifo.sv - DEPTH x W return-address LIFO, saturating depth
module ras_lifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 12,
  localparam int DW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [DW-1:0] depth,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] depth_q, depth_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;

  assign empty  = (depth_q == '0);
  assign full   = (depth_q == DW'(DEPTH));
  assign depth  = depth_q;
  assign wr_idx = AW'(depth_q);
  assign rd_idx = AW'(depth_q - DW'(1));
  assign dout   = mem_q[rd_idx];

  // Push-when-full and pop-when-empty fall through as no-ops.
  always_comb begin
    depth_d = depth_q;
    mem_d   = mem_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      depth_d       = depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_reg_stack.sv
// rtl/pc_reg_stack.sv - PC register with hardware return-address stack and sticky error flags
module pc_reg_stack
  import pc_reg_stack_pkg::*;
#(
  parameter  int              PC_W      = DEF_PC_W,
  parameter  int              DEPTH     = 4,
  parameter  logic [PC_W-1:0] RESET_VEC = DEF_RESET_VEC,
  localparam int              DW        = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] next_pc,
  input  logic            clr_err,
  output logic [PC_W-1:0] pc,
  output logic [DW-1:0]   depth,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            unf,
  output logic            conflict
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            conflict_q, conflict_d;
  logic [2:0]      act;
  logic            push, pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty, ras_full;

  ras_lifo #(.DEPTH(DEPTH), .W(PC_W)) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_q + PC_W'(1)),
    .dout  (ras_top),
    .depth (depth),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign act  = sel_action(en, call, ret);
  assign push = (act == ACT_CALL) && !ras_full;
  assign pop  = (act == ACT_RET)  && !ras_empty;

  always_comb begin
    pc_d = pc_q;
    case (act)
      ACT_EN:   pc_d = next_pc;
      ACT_CALL: if (!ras_full)  pc_d = next_pc;
      ACT_RET:  if (!ras_empty) pc_d = ras_top;
      default:  pc_d = pc_q;
    endcase
  end

  // A same-cycle error event overrides clr_err.
  always_comb begin
    ovf_d      = (ovf_q      && !clr_err) || ((act == ACT_CALL) && ras_full);
    unf_d      = (unf_q      && !clr_err) || ((act == ACT_RET)  && ras_empty);
    conflict_d = (conflict_q && !clr_err) ||  (act == ACT_CONFLICT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      conflict_q <= conflict_d;
    end
  end

  assign pc       = pc_q;
  assign empty    = ras_empty;
  assign full     = ras_full;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_pc_reg_stack.sv
// tb/tb_pc_reg_stack.sv - directed and randomized checks of pc_reg_stack against a queue model
module tb_pc_reg_stack;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, en, call, ret, clr_err;
  logic [11:0] next_pc, pc;
  logic [2:0]  depth;
  logic        empty, full, ovf, unf, conflict;

  logic [11:0] m_pc;
  logic [11:0] m_stk [$];
  bit          m_ovf, m_unf, m_conf;
  int          total  = 0;
  int          passes = 0;

  pc_reg_stack dut (
    .clk(clk), .reset(reset), .en(en), .call(call), .ret(ret),
    .next_pc(next_pc), .clr_err(clr_err), .pc(pc), .depth(depth),
    .empty(empty), .full(full), .ovf(ovf), .unf(unf), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string ctx);
    chk({ctx, "/pc"},       32'(pc),       32'(m_pc));
    chk({ctx, "/depth"},    32'(depth),    32'(m_stk.size()));
    chk({ctx, "/empty"},    32'(empty),    32'(m_stk.size() == 0));
    chk({ctx, "/full"},     32'(full),     32'(m_stk.size() == DEPTH));
    chk({ctx, "/ovf"},      32'(ovf),      32'(m_ovf));
    chk({ctx, "/unf"},      32'(unf),      32'(m_unf));
    chk({ctx, "/conflict"}, 32'(conflict), 32'(m_conf));
  endtask

  task automatic model_reset();
    m_pc = 12'h000;
    m_stk.delete();
    m_ovf = 0; m_unf = 0; m_conf = 0;
  endtask

  // One clock: drive strobes, advance the model by the priority rules, compare.
  task automatic step(input bit e, input bit c, input bit r, input logic [11:0] n,
                      input bit clr, input string ctx);
    bit so, su, sc;
    so = 0; su = 0; sc = 0;
    en = e; call = c; ret = r; next_pc = n; clr_err = clr;
    @(posedge clk);
    if (c && r) sc = 1;
    else if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else su = 1;
    end else if (c) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(12'(m_pc + 12'd1));
        m_pc = n;
      end else so = 1;
    end else if (e) m_pc = n;
    m_ovf  = (m_ovf  && !clr) || so;
    m_unf  = (m_unf  && !clr) || su;
    m_conf = (m_conf && !clr) || sc;
    #1;
    chk_all(ctx);
  endtask

  initial begin
    logic [11:0] exp_ret [4];
    reset = 1'b1; en = 0; call = 0; ret = 0; clr_err = 0; next_pc = '0;
    model_reset();
    #2;
    chk_all("reset");
    #10 reset = 1'b0;

    // Plain advance and hold
    step(1, 0, 0, 12'h0F0, 0, "t2_load");
    step(1, 0, 0, 12'hA00, 0, "t2_en");
    chk("t2_pc", 32'(pc), 32'hA00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 12'(i * 7 + 3), 0, "t2_hold");
    chk("t2_hold_pc", 32'(pc), 32'hA00);

    // Single call/ret
    step(1, 0, 0, 12'h0F0, 0, "t3_load");
    step(0, 1, 0, 12'h300, 0, "t3_call");
    chk("t3_call_pc", 32'(pc), 32'h300);
    step(0, 0, 1, 12'h555, 0, "t3_ret");
    chk("t3_ret_pc", 32'(pc), 32'h0F1);
    chk("t3_empty", 32'(empty), 32'd1);

    // Fill, overflow, drain, underflow
    step(1, 0, 0, 12'h010, 0, "t4_load");
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 12'(i * 12'h100), 0, "t4_call");
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_pc", 32'(pc), 32'h400);
    step(0, 1, 0, 12'h500, 0, "t4_ovf");
    chk("t4_ovf_pc", 32'(pc), 32'h400);
    chk("t4_ovf", 32'(ovf), 32'd1);
    exp_ret[0] = 12'h301; exp_ret[1] = 12'h201; exp_ret[2] = 12'h101; exp_ret[3] = 12'h011;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 12'h0, 0, "t4_ret");
      chk("t4_ret_pc", 32'(pc), 32'(exp_ret[i]));
    end
    step(0, 0, 1, 12'h0, 0, "t4_unf");
    chk("t4_unf_pc", 32'(pc), 32'h011);
    chk("t4_unf", 32'(unf), 32'd1);

    // Asynchronous reset mid-call, checked before any clock edge
    step(1, 0, 0, 12'h0AB, 0, "t1_pre");
    step(0, 1, 0, 12'h0CD, 0, "t1_push");
    en = 0; call = 1; ret = 0; next_pc = 12'h777;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_all("t1_async");
    @(posedge clk);
    #1 chk_all("t1_held");
    #3 begin reset = 1'b0; call = 0; end

    // Return-address wrap
    step(1, 0, 0, 12'hFFF, 0, "t5_load");
    step(0, 1, 0, 12'h050, 0, "t5_call");
    step(0, 0, 1, 12'h0, 0, "t5_ret");
    chk("t5_wrap_pc", 32'(pc), 32'h000);

    // Conflict, clear, and clear racing an underflow
    step(1, 0, 0, 12'h200, 0, "t6_load");
    step(0, 1, 0, 12'h123, 0, "t6_call");
    step(1, 1, 1, 12'h456, 0, "t6_conflict");
    chk("t6_conf_pc", 32'(pc), 32'h123);
    chk("t6_conf_depth", 32'(depth), 32'd1);
    chk("t6_conflict", 32'(conflict), 32'd1);
    step(0, 0, 0, 12'h0, 1, "t6_clr");
    chk("t6_clr_conf", 32'(conflict), 32'd0);
    step(0, 0, 1, 12'h0, 0, "t6_pop");
    chk("t6_pop_pc", 32'(pc), 32'h201);
    step(0, 0, 1, 12'h0, 1, "t6_clr_unf");
    chk("t6_unf_wins", 32'(unf), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(bit'($urandom_range(0, 1)), r < 30, (r >= 25) && (r < 60),
           12'($urandom), $urandom_range(0, 15) == 0, "rand");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
